// File: rtl/ecc_scrub_ctrl_if.sv
// Memory port and Hamming decoder bundle used by the ECC scrubber.
interface ecc_scrub_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [11:0]       mem_rdata;
    logic              mem_wr;
    logic [11:0]       mem_wdata;
    logic [11:0]       dec_code;
    logic [3:0]        dec_syndrome;

    // Scrubber side: drives the memory strobes and the decoder input
    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        output dec_code,
        input  mem_rdata,
        input  dec_syndrome
    );

    // Memory/decoder side
    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        input  dec_code,
        output mem_rdata,
        output dec_syndrome
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber for Hamming(12,8) protected memory: walks every address,
// writes back single-bit-corrected words and counts corrected/uncorrectable words.
module ecc_scrub_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    ecc_scrub_ctrl_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              err_valid,
    output logic              err_uncorr,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);
    localparam int unsigned CODE_W = 12;
    localparam int unsigned SYND_W = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [SYND_W-1:0] LAST_CORR    = SYND_W'(CODE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_NEXT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] wdata_q;

    // Control decoded from the current state
    logic rd_c;
    logic wr_c;
    logic launch_c;
    logic capture_c;
    logic check_c;
    logic step_c;
    logic last_c;

    // Syndrome classification
    logic [SYND_W-1:0] synd_c;
    logic              synd_nz_c;
    logic              corr_c;
    logic              uncorr_c;
    logic [CODE_W-1:0] flip_c;

    // Syndrome 1..12 names the flipped bit position; 13..15 cannot be a single error
    always_comb begin
        synd_c    = bus.dec_syndrome;
        synd_nz_c = (synd_c != '0);
        corr_c    = synd_nz_c && (synd_c <= LAST_CORR);
        uncorr_c  = synd_c > LAST_CORR;
        flip_c    = CODE_W'(1) << (synd_c - SYND_W'(1));
    end

    assign last_c = (addr_q == LAST_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (!hold) state_d = S_WAIT;
            S_WAIT:  state_d = S_CHECK;
            S_CHECK: state_d = corr_c ? S_WRITE : S_NEXT;
            S_WRITE: if (!hold) state_d = S_NEXT;
            S_NEXT:  state_d = last_c ? S_IDLE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath control decode
    always_comb begin
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        launch_c  = 1'b0;
        capture_c = 1'b0;
        check_c   = 1'b0;
        step_c    = 1'b0;
        unique case (state_q)
            S_IDLE:  launch_c  = start;
            S_READ:  rd_c      = !hold;
            S_WAIT:  capture_c = 1'b1;
            S_CHECK: check_c   = 1'b1;
            S_WRITE: wr_c      = !hold;
            S_NEXT:  step_c    = !last_c;
            default: ;
        endcase
    end

    // Word address walks 0..DEPTH-1 and is held after the pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (launch_c) begin
            addr_q <= '0;
        end else if (step_c) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    // Read data capture and corrected write-back word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (capture_c) begin
                code_q <= bus.mem_rdata;
            end
            if (check_c && corr_c) begin
                wdata_q <= code_q ^ flip_c;
            end
        end
    end

    // Saturating error counters, cleared only by an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (launch_c) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (check_c) begin
            if (corr_c && (corr_count != CNT_MAX)) begin
                corr_count <= corr_count + CNT_W'(1);
            end
            if (uncorr_c && (uncorr_count != CNT_MAX)) begin
                uncorr_count <= uncorr_count + CNT_W'(1);
            end
        end
    end

    // Error report for the word just checked, one cycle after CHECK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid  <= 1'b0;
            err_uncorr <= 1'b0;
            err_addr   <= '0;
        end else begin
            err_valid  <= check_c && synd_nz_c;
            err_uncorr <= check_c && uncorr_c;
            if (check_c && synd_nz_c) begin
                err_addr <= addr_q;
            end
        end
    end

    // Status flags: busy follows the upcoming state, done pulses after the last NEXT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_q == S_NEXT) && last_c;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = rd_c;
    assign bus.mem_wr    = wr_c;
    assign bus.mem_wdata = wdata_q;
    assign bus.dec_code  = code_q;

    // The memory port never sees a read and a write together
    a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(rd_c && wr_c));

    // Strobes only come from READ and WRITE
    a_rd_state: assert property (@(posedge clk) disable iff (rst) rd_c |-> (state_q == S_READ));
    a_wr_state: assert property (@(posedge clk) disable iff (rst) wr_c |-> (state_q == S_WRITE));
endmodule
